fifo_regif_slave: RTL and testbench
===================================

// Module: fifo_regif_slave
// PURPOSE
//   Register-mapped responder for the app-side CPU bus. Bridges 2-bit-address read/write
//   accesses to two byte FIFOs facing USB_CDC: IN (CPU->host, valid/ready source) and
//   OUT (host->CPU, valid/ready sink). Status bits and edge IRQs let a polling/sleeping
//   initiator move bytes without handshake knowledge.
// PARAMETERS
//   IN_DEPTH   8  IN FIFO depth in bytes; power of 2, >=2
//   OUT_DEPTH  8  OUT FIFO depth in bytes; power of 2, >=2
// PORTS
//   clk_i        in   1  clock
//   rst_i        in   1  synchronous reset, active-high
//   sel_i        in   1  bus select; read_i/write_i ignored while low
//   read_i       in   1  read strobe (qualified by sel_i)
//   write_i      in   1  write strobe (qualified by sel_i)
//   addr_i       in   2  register address
//   data_i       in   8  write data
//   data_o       out  8  read data, registered
//   in_irq_o     out  1  IN FIFO space-available pulse
//   out_irq_o    out  1  OUT FIFO data-available pulse
//   in_data_o    out  8  IN FIFO head byte to USB_CDC
//   in_valid_o   out  1  IN FIFO not empty
//   in_ready_i   in   1  USB_CDC consumes in_data_o when in_valid_o & in_ready_i
//   out_data_i   in   8  byte from USB_CDC
//   out_valid_i  in   1  out_data_i valid, stable until consumed
//   out_ready_o  out  1  OUT FIFO not full; byte pushed when out_valid_i & out_ready_o
// BEHAVIOUR
//   Reset: FIFOs empty; data_o=0, irqs=0, in_valid_o=0, in_data_o=0, out_ready_o=1;
//     CTRL=2'b11; sticky flags=0. Reset mid-transfer discards all FIFO contents.
//   Register map (rd=sel&read, wr=sel&write):
//     0 CTRL     R/W  [0] in_irq_en, [1] out_irq_en; [7:2] read 0, writes ignored
//     1 IN_STAT  R    [0] IN not full, [1] in_drop sticky; W: push data_i to IN FIFO
//     2 OUT_STAT R    [0] OUT not empty, [1] out_undr sticky; W: ignored
//     3 OUT_DATA R    pop OUT FIFO, return popped byte; W: ignored
//   Read latency 1: data_o updates on the clock edge after rd, holds until next rd.
//   rd and wr in same cycle: both serviced; rd returns pre-write state.
//   Full/empty flags are evaluated from state at start of cycle (registered counts).
//   Write to IN when full: byte dropped, in_drop set, even if in_ready_i pops that cycle.
//   Read OUT_DATA when empty: data_o=8'h00, no pop, out_undr set.
//   Sticky flags clear on read of their register; set-and-clear same cycle -> set wins.
//   Simultaneous push/pop on same FIFO (not full/not empty): both happen, count unchanged.
//   Pointers wrap modulo depth; count width $clog2(DEPTH)+1.
//   in_irq_o: 1-cycle pulse when IN count goes DEPTH -> DEPTH-1 and in_irq_en=1.
//   out_irq_o: 1-cycle pulse when OUT count goes 0 -> nonzero and out_irq_en=1.
//   Streams: in_data_o is head of IN FIFO (first-word fall-through), valid same cycle
//     in_valid_o rises (one cycle after push); out_ready_o from registered count.
// CONFIGURATION
//   FIFO_REGIF_LEVELS_EN defined: IN_STAT[7:4] = free entries, OUT_STAT[7:4] = used
//     entries, each saturated at 15. Undefined: those bits read 0; bits [3:2] always 0.
// STRUCTURE
//   Shared package/include fifo_regif_pkg: register address constants (CTRL, IN_STAT,
//   OUT_STAT, OUT_DATA), status bit positions, CTRL reset value.
//   Sub-module sync_byte_fifo (DEPTH param, push/pop/data/count, FWFT), instantiated
//   twice; top holds decode, sticky flags, irq edge logic, data_o register.
// TESTING
//   Reset, rd addr 0 -> data_o=8'h03; rd addr 2 -> 8'h00; out_ready_o=1, in_valid_o=0.
//   Push 8'h41 on out_valid_i -> out_irq_o one pulse; rd 2 -> 8'h01; rd 3 -> 8'h41.
//   Hold in_ready_i=0, write 9 bytes to addr 1 (depth 8) -> rd 1 = 8'h02, 9th dropped;
//     second rd 1 = 8'h00.
//   From full IN, in_ready_i=1 one cycle -> in_irq_o pulse, in_data_o = 2nd byte written.
//   Rd addr 3 on empty OUT -> data_o=8'h00, rd 2 = 8'h02, next rd 2 = 8'h00.
//   CTRL=0, fill OUT from empty -> out_irq_o stays 0; LEVELS_EN build: rd 2 = 8'h11 after 1 byte.

Source files
------------

// File: rtl/fifo_regif_pkg.sv
// Shared definitions for the CPU-bus FIFO responder: register addresses, status
// and control bit positions, CTRL reset value and the level saturation helper.
package fifo_regif_pkg;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_IN_STAT  = 2'd1,
    REG_OUT_STAT = 2'd2,
    REG_OUT_DATA = 2'd3
  } reg_addr_e;

  localparam int CTRL_IN_IRQ_EN  = 0;
  localparam int CTRL_OUT_IRQ_EN = 1;
  localparam logic [1:0] CTRL_RST_VAL = 2'b11;

  localparam int STAT_LEVEL_FLAG = 0;
  localparam int STAT_STICKY     = 1;
  localparam int STAT_LEVEL_LSB  = 4;

  // Fill levels are reported in a 4-bit field, so anything above 15 reads as 15.
  function automatic logic [3:0] sat15(input int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head; overflowing pushes and
// underflowing pops are ignored, head reads 0 while empty.
module sync_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign count_o = r_count;
  assign data_o  = empty_o ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; pointers and count alone define the contents.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/fifo_regif_slave.sv
// Register-mapped CPU responder bridging two byte FIFOs to the USB_CDC streams.
// Build option FIFO_REGIF_LEVELS_EN reports FIFO fill levels in status bits [7:4].
module fifo_regif_slave
  import fifo_regif_pkg::*;
#(
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sel_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       in_irq_o,
  output logic       out_irq_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o
);

  localparam int INCW  = $clog2(IN_DEPTH) + 1;
  localparam int OUTCW = $clog2(OUT_DEPTH) + 1;

  logic            w_rd;
  logic            w_wr;
  reg_addr_e       w_addr;
  logic            w_in_push;
  logic            w_in_pop;
  logic            w_in_full;
  logic            w_in_empty;
  logic [INCW-1:0] w_in_count;
  logic [7:0]      w_in_head;
  logic            w_out_push;
  logic            w_out_pop;
  logic            w_out_full;
  logic            w_out_empty;
  logic [OUTCW-1:0] w_out_count;
  logic [7:0]      w_out_head;
  logic [7:0]      w_in_stat;
  logic [7:0]      w_out_stat;
  logic [3:0]      w_in_lvl;
  logic [3:0]      w_out_lvl;

  logic [1:0]      r_ctrl;
  logic            r_in_drop;
  logic            r_out_undr;
  logic [7:0]      r_data;
  logic            r_in_irq;
  logic            r_out_irq;

  assign w_rd       = sel_i & read_i;
  assign w_wr       = sel_i & write_i;
  assign w_addr     = reg_addr_e'(addr_i);
  assign w_in_push  = w_wr & (w_addr == REG_IN_STAT);
  assign w_in_pop   = in_ready_i & ~w_in_empty;
  assign w_out_push = out_valid_i & ~w_out_full;
  assign w_out_pop  = w_rd & (w_addr == REG_OUT_DATA);

  sync_byte_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_in_push),
    .pop_i   (w_in_pop),
    .data_i  (data_i),
    .data_o  (w_in_head),
    .count_o (w_in_count),
    .full_o  (w_in_full),
    .empty_o (w_in_empty)
  );

  sync_byte_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_out_push),
    .pop_i   (w_out_pop),
    .data_i  (out_data_i),
    .data_o  (w_out_head),
    .count_o (w_out_count),
    .full_o  (w_out_full),
    .empty_o (w_out_empty)
  );

`ifdef FIFO_REGIF_LEVELS_EN
  assign w_in_lvl  = sat15(IN_DEPTH - int'(w_in_count));
  assign w_out_lvl = sat15(int'(w_out_count));
`else
  assign w_in_lvl  = 4'h0;
  assign w_out_lvl = 4'h0;
`endif

  always_comb begin
    w_in_stat  = 8'h00;
    w_out_stat = 8'h00;
    w_in_stat[STAT_LEVEL_FLAG]            = ~w_in_full;
    w_in_stat[STAT_STICKY]                = r_in_drop;
    w_in_stat[STAT_LEVEL_LSB +: 4]        = w_in_lvl;
    w_out_stat[STAT_LEVEL_FLAG]           = ~w_out_empty;
    w_out_stat[STAT_STICKY]               = r_out_undr;
    w_out_stat[STAT_LEVEL_LSB +: 4]       = w_out_lvl;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl     <= CTRL_RST_VAL;
      r_in_drop  <= 1'b0;
      r_out_undr <= 1'b0;
      r_data     <= 8'h00;
      r_in_irq   <= 1'b0;
      r_out_irq  <= 1'b0;
    end else begin
      // A full FIFO cannot accept a push, so a pop from full is the DEPTH -> DEPTH-1 step.
      r_in_irq  <= r_ctrl[CTRL_IN_IRQ_EN] & w_in_pop & (w_in_count == INCW'(IN_DEPTH));
      r_out_irq <= r_ctrl[CTRL_OUT_IRQ_EN] & w_out_push & (w_out_count == '0);

      if (w_wr && w_addr == REG_CTRL) r_ctrl <= data_i[1:0];

      if (w_in_push && w_in_full)                r_in_drop <= 1'b1;
      else if (w_rd && w_addr == REG_IN_STAT)    r_in_drop <= 1'b0;

      if (w_out_pop && w_out_empty)              r_out_undr <= 1'b1;
      else if (w_rd && w_addr == REG_OUT_STAT)   r_out_undr <= 1'b0;

      if (w_rd) begin
        case (w_addr)
          REG_CTRL:     r_data <= {6'b0, r_ctrl};
          REG_IN_STAT:  r_data <= w_in_stat;
          REG_OUT_STAT: r_data <= w_out_stat;
          REG_OUT_DATA: r_data <= w_out_head;
          default:      r_data <= 8'h00;
        endcase
      end
    end
  end

  assign data_o      = r_data;
  assign in_irq_o    = r_in_irq;
  assign out_irq_o   = r_out_irq;
  assign in_data_o   = w_in_head;
  assign in_valid_o  = ~w_in_empty;
  assign out_ready_o = ~w_out_full;

endmodule

// File: tb/tb_fifo_regif_slave.sv
// Directed bench for fifo_regif_slave: a register-access vector table followed by
// hand-written FIFO fill/drain, IRQ and reset sequences.
module tb_fifo_regif_slave;

`ifdef FIFO_REGIF_LEVELS_EN
  localparam bit LV = 1'b1;
`else
  localparam bit LV = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       sel_i = 1'b0;
  logic       read_i = 1'b0;
  logic       write_i = 1'b0;
  logic [1:0] addr_i = 2'd0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       in_irq_o;
  logic       out_irq_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_regif_slave #(.IN_DEPTH(8), .OUT_DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sel_i       (sel_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .in_irq_o    (in_irq_o),
    .out_irq_o   (out_irq_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic       s;
    logic       r;
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [7:0] stat(input int lvl, input logic b1, input logic b0);
    logic [3:0] l;
    l = (lvl > 15) ? 4'hF : lvl[3:0];
    return {(LV ? l : 4'h0), 2'b00, b1, b0};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // One bus cycle; outputs are sampled 1 time unit after the active edge.
  task automatic op(input logic s, input logic r, input logic w,
                    input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_i);
    sel_i = s; read_i = r; write_i = w; addr_i = a; data_i = d;
    @(posedge clk_i);
    #1;
    sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a);
    op(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    op(1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    logic seen;

    vecs[0]  = '{"ctrl_rst",      1, 1, 0, 2'd0, 8'h00, 1, 8'h03};
    vecs[1]  = '{"out_stat_rst",  1, 1, 0, 2'd2, 8'h00, 1, stat(0, 0, 0)};
    vecs[2]  = '{"in_stat_rst",   1, 1, 0, 2'd1, 8'h00, 1, stat(8, 0, 1)};
    vecs[3]  = '{"ctrl_wr_ff",    1, 0, 1, 2'd0, 8'hFF, 0, 8'h00};
    vecs[4]  = '{"ctrl_masked",   1, 1, 0, 2'd0, 8'h00, 1, 8'h03};
    vecs[5]  = '{"ctrl_wr_01",    1, 0, 1, 2'd0, 8'h01, 0, 8'h00};
    vecs[6]  = '{"ctrl_rd_01",    1, 1, 0, 2'd0, 8'h00, 1, 8'h01};
    vecs[7]  = '{"ctrl_rdwr_pre", 1, 1, 1, 2'd0, 8'h02, 1, 8'h01};
    vecs[8]  = '{"ctrl_rd_02",    1, 1, 0, 2'd0, 8'h00, 1, 8'h02};
    vecs[9]  = '{"unsel_hold",    0, 1, 1, 2'd0, 8'h00, 1, 8'h02};
    vecs[10] = '{"ctrl_unsel",    1, 1, 0, 2'd0, 8'h00, 1, 8'h02};
    vecs[11] = '{"wr_out_stat",   1, 0, 1, 2'd2, 8'hFF, 0, 8'h00};
    vecs[12] = '{"wr_out_data",   1, 0, 1, 2'd3, 8'hFF, 0, 8'h00};
    vecs[13] = '{"out_stat_ign",  1, 1, 0, 2'd2, 8'h00, 1, stat(0, 0, 0)};
    vecs[14] = '{"in_stat_ign",   1, 1, 0, 2'd1, 8'h00, 1, stat(8, 0, 1)};
    vecs[15] = '{"ctrl_restore",  1, 0, 1, 2'd0, 8'h03, 0, 8'h00};

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_data_o", data_o, 8'h00);
    check("rst_out_ready", {7'b0, out_ready_o}, 8'h01);
    check("rst_in_valid", {7'b0, in_valid_o}, 8'h00);
    check("rst_in_data", in_data_o, 8'h00);
    check("rst_irqs", {6'b0, in_irq_o, out_irq_o}, 8'h00);

    foreach (vecs[i]) begin
      op(vecs[i].s, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
      if (vecs[i].chk) check(vecs[i].name, data_o, vecs[i].exp);
    end
    check("in_valid_idle", {7'b0, in_valid_o}, 8'h00);

    // OUT push raises one irq pulse, then status and data reads.
    out_valid_i = 1'b1; out_data_i = 8'h41;
    idle();
    out_valid_i = 1'b0;
    check("out_irq_pulse", {7'b0, out_irq_o}, 8'h01);
    idle();
    check("out_irq_drop", {7'b0, out_irq_o}, 8'h00);
    rd(2'd2); check("out_stat_one", data_o, stat(1, 0, 1));
    rd(2'd3); check("out_data_41", data_o, 8'h41);
    rd(2'd2); check("out_stat_empty", data_o, stat(0, 0, 0));

    // OUT underflow sets the sticky flag, read clears it.
    rd(2'd3); check("undr_data", data_o, 8'h00);
    rd(2'd2); check("undr_sticky", data_o, stat(0, 1, 0));
    rd(2'd2); check("undr_cleared", data_o, stat(0, 0, 0));

    // Nine writes into an 8-deep IN FIFO with the sink stalled.
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(2'd1, 8'h10 + 8'(i));
      seen |= in_irq_o;
      if (i == 0) begin
        check("in_valid_first", {7'b0, in_valid_o}, 8'h01);
        check("in_head_first", in_data_o, 8'h10);
      end
    end
    check("in_irq_quiet_fill", {7'b0, seen}, 8'h00);
    rd(2'd1); check("in_drop_sticky", data_o, stat(0, 1, 0));
    rd(2'd1); check("in_drop_cleared", data_o, stat(0, 0, 0));

    // One pop from full gives a space-available pulse.
    in_ready_i = 1'b1;
    idle();
    in_ready_i = 1'b0;
    check("in_irq_pulse", {7'b0, in_irq_o}, 8'h01);
    check("in_head_second", in_data_o, 8'h11);
    idle();
    check("in_irq_drop", {7'b0, in_irq_o}, 8'h00);
    rd(2'd1); check("in_stat_one_free", data_o, stat(1, 0, 1));

    for (int i = 1; i < 8; i++) begin
      check("in_drain_order", in_data_o, 8'h10 + 8'(i));
      in_ready_i = 1'b1;
      idle();
      in_ready_i = 1'b0;
    end
    check("in_drained_valid", {7'b0, in_valid_o}, 8'h00);
    check("in_drained_data", in_data_o, 8'h00);

    // Write to full IN is dropped even though the sink pops in the same cycle.
    for (int i = 0; i < 8; i++) wr(2'd1, 8'h20 + 8'(i));
    in_ready_i = 1'b1;
    wr(2'd1, 8'h99);
    in_ready_i = 1'b0;
    check("in_head_after_pop", in_data_o, 8'h21);
    rd(2'd1); check("in_drop_with_pop", data_o, stat(1, 1, 1));

    // IRQs disabled: filling OUT from empty must not pulse.
    wr(2'd0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_valid_i = 1'b1; out_data_i = 8'h30 + 8'(i);
      idle();
      seen |= out_irq_o;
    end
    out_valid_i = 1'b0;
    check("out_irq_disabled", {7'b0, seen}, 8'h00);
    check("out_full_ready", {7'b0, out_ready_o}, 8'h00);
    rd(2'd2); check("out_stat_full", data_o, stat(8, 0, 1));
    rd(2'd3); check("out_data_30", data_o, 8'h30);
    rd(2'd0); check("ctrl_zero", data_o, 8'h00);

    // Reset mid-transfer flushes both FIFOs and restores CTRL.
    rst_i = 1'b1;
    idle();
    rst_i = 1'b0;
    check("mid_rst_out_ready", {7'b0, out_ready_o}, 8'h01);
    check("mid_rst_in_valid", {7'b0, in_valid_o}, 8'h00);
    check("mid_rst_data_o", data_o, 8'h00);
    rd(2'd0); check("mid_rst_ctrl", data_o, 8'h03);
    rd(2'd2); check("mid_rst_out_stat", data_o, stat(0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
